// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receiver.
//  - state_t     : receiver FSM states (IDLE / MARK / SPACE)
//  - MAX_ELEM    : maximum dots/dashes held in one symbol
//  - LEN_W       : width of the symbol element count
//  - ASCII_*     : fixed output characters (word space, unknown symbol)
//  - ELEM_*      : element encoding inside the symbol shift register
//  - valid_mask(): selects the low len bits of a symbol pattern
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam int MAX_ELEM = 6;
  localparam int LEN_W    = 3;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  // Bit i is set when element i of a len-element symbol is present.
  function automatic logic [MAX_ELEM-1:0] valid_mask(input logic [LEN_W-1:0] len);
    logic [MAX_ELEM-1:0] m;
    for (int i = 0; i < MAX_ELEM; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/morse_if.sv
// Keyed-line input and decoded-character output of the Morse receiver.
//  din   : keyed line, 1 = mark (tone), 0 = space; sampled every clock
//  ascii : last decoded character, held until the next one
//  start : one-cycle strobe marking a new ascii value
//  state : receiver FSM state, exposed for observation
// Handshake: start acts as a valid with no ready. The sink has no way to
// stall the receiver and must capture ascii in the cycle start is high;
// ascii is stable from that cycle until the next strobe.
// Modports: slave = receiver side, master = line source / character sink.
interface morse_if;
  import morse_pkg::*;

  logic       din;
  logic [7:0] ascii;
  logic       start;
  state_t     state;

  modport master (
    output din,
    input  ascii,
    input  start,
    input  state
  );

  modport slave (
    input  din,
    output ascii,
    output start,
    output state
  );

endinterface

// File: rtl/morse_lut.sv
// Combinational Morse symbol decoder.
//  len     : number of elements in the symbol (1..MAX_ELEM)
//  pattern : elements, first element in the highest used bit, last in bit 0
//            (dot = 0, dash = 1)
//  ovf     : symbol had more than MAX_ELEM elements
//  ascii   : uppercase letter / digit, or '?' for overflow and unmapped codes
module morse_lut
  import morse_pkg::*;
(
  input  logic [LEN_W-1:0]    len,
  input  logic [MAX_ELEM-1:0] pattern,
  input  logic                ovf,
  output logic [7:0]          ascii
);

  logic [MAX_ELEM-1:0] code;

  always_comb begin
    code  = pattern & valid_mask(len);
    ascii = ASCII_UNKNOWN;
    if (!ovf) begin
      // Key is {len, code}; len disambiguates codes sharing the same bits.
      case ({len, code})
        9'b010_000001: ascii = 8'h41; // A .-
        9'b100_001000: ascii = 8'h42; // B -...
        9'b100_001010: ascii = 8'h43; // C -.-.
        9'b011_000100: ascii = 8'h44; // D -..
        9'b001_000000: ascii = 8'h45; // E .
        9'b100_000010: ascii = 8'h46; // F ..-.
        9'b011_000110: ascii = 8'h47; // G --.
        9'b100_000000: ascii = 8'h48; // H ....
        9'b010_000000: ascii = 8'h49; // I ..
        9'b100_000111: ascii = 8'h4A; // J .---
        9'b011_000101: ascii = 8'h4B; // K -.-
        9'b100_000100: ascii = 8'h4C; // L .-..
        9'b010_000011: ascii = 8'h4D; // M --
        9'b010_000010: ascii = 8'h4E; // N -.
        9'b011_000111: ascii = 8'h4F; // O ---
        9'b100_000110: ascii = 8'h50; // P .--.
        9'b100_001101: ascii = 8'h51; // Q --.-
        9'b011_000010: ascii = 8'h52; // R .-.
        9'b011_000000: ascii = 8'h53; // S ...
        9'b001_000001: ascii = 8'h54; // T -
        9'b011_000001: ascii = 8'h55; // U ..-
        9'b100_000001: ascii = 8'h56; // V ...-
        9'b011_000011: ascii = 8'h57; // W .--
        9'b100_001001: ascii = 8'h58; // X -..-
        9'b100_001011: ascii = 8'h59; // Y -.--
        9'b100_001100: ascii = 8'h5A; // Z --..
        9'b101_011111: ascii = 8'h30; // 0 -----
        9'b101_001111: ascii = 8'h31; // 1 .----
        9'b101_000111: ascii = 8'h32; // 2 ..---
        9'b101_000011: ascii = 8'h33; // 3 ...--
        9'b101_000001: ascii = 8'h34; // 4 ....-
        9'b101_000000: ascii = 8'h35; // 5 .....
        9'b101_010000: ascii = 8'h36; // 6 -....
        9'b101_011000: ascii = 8'h37; // 7 --...
        9'b101_011100: ascii = 8'h38; // 8 ---..
        9'b101_011110: ascii = 8'h39; // 9 ----.
        default:       ascii = ASCII_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/top_block.sv
// Morse receiver: one clock = one Morse time unit.
// Measures mark/space run lengths on the keyed line, collects dots and
// dashes into a symbol, and emits the decoded character (or a word space)
// with a one-cycle strobe.
//  clk   : system clock
//  reset : asynchronous, active-low
//  bus   : morse_if.slave (din in; ascii, start, state out)
// Parameters:
//  DASH_MIN : mark run >= DASH_MIN is a dash, shorter is a dot
//  LGAP_MIN : space run reaching LGAP_MIN ends a letter
//  WGAP_MIN : space run reaching WGAP_MIN ends a word (must exceed LGAP_MIN)
//  CNT_W    : run counter width, counter saturates at all-ones
module top_block
  import morse_pkg::*;
#(
  parameter int DASH_MIN = 2,
  parameter int LGAP_MIN = 2,
  parameter int WGAP_MIN = 5,
  parameter int CNT_W    = 4
) (
  input  logic   clk,
  input  logic   reset,
  morse_if.slave bus
);

  state_t              state, state_next;
  logic [CNT_W-1:0]    run, run_next;
  logic [MAX_ELEM-1:0] pattern, pattern_next;
  logic [LEN_W-1:0]    len, len_next;
  logic                ovf, ovf_next;
  logic                pend, pend_next;
  logic [7:0]          ascii_q;
  logic                start_q;

  // Symbol after this cycle's append, before any letter-end clear.
  logic [MAX_ELEM-1:0] buf_pattern;
  logic [LEN_W-1:0]    buf_len;
  logic                buf_ovf;

  logic                emit_letter;
  logic                emit_space;
  logic [7:0]          lut_ascii;

  morse_lut u_lut (
    .len     (buf_len),
    .pattern (buf_pattern),
    .ovf     (buf_ovf),
    .ascii   (lut_ascii)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      run     <= '0;
      pattern <= '0;
      len     <= '0;
      ovf     <= 1'b0;
      pend    <= 1'b0;
      ascii_q <= 8'h00;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      run     <= run_next;
      pattern <= pattern_next;
      len     <= len_next;
      ovf     <= ovf_next;
      pend    <= pend_next;
      start_q <= emit_letter | emit_space;
      if (emit_letter) begin
        ascii_q <= lut_ascii;
      end else if (emit_space) begin
        ascii_q <= ASCII_SPACE;
      end
    end
  end

  always_comb begin
    state_next   = state;
    run_next     = run;
    buf_pattern  = pattern;
    buf_len      = len;
    buf_ovf      = ovf;
    pattern_next = pattern;
    len_next     = len;
    ovf_next     = ovf;
    pend_next    = pend;
    emit_letter  = 1'b0;
    emit_space   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.din) begin
          state_next = MARK;
          run_next   = CNT_W'(1);
        end
      end
      MARK: begin
        if (bus.din) begin
          run_next = (run == {CNT_W{1'b1}}) ? run : run + 1'b1;
        end else begin
          state_next = SPACE;
          run_next   = CNT_W'(1);
          // A full buffer keeps its contents; the extra element only
          // marks the symbol as overflowed.
          if (len == LEN_W'(MAX_ELEM)) begin
            buf_ovf = 1'b1;
          end else begin
            buf_pattern = {pattern[MAX_ELEM-2:0],
                           (run >= CNT_W'(DASH_MIN)) ? ELEM_DASH : ELEM_DOT};
            buf_len     = len + 1'b1;
          end
        end
      end
      SPACE: begin
        if (bus.din) begin
          state_next = MARK;
          run_next   = CNT_W'(1);
        end else begin
          run_next = (run == {CNT_W{1'b1}}) ? run : run + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        run_next   = '0;
      end
    endcase

    // Gap thresholds are detected on the counter value being written, so the
    // strobe register loads on the same edge that samples the threshold zero.
    // Equality fires once per gap even when the counter later saturates.
    if (state_next == SPACE && run_next == CNT_W'(LGAP_MIN) &&
        (buf_len != '0 || buf_ovf)) begin
      emit_letter = 1'b1;
      pend_next   = 1'b1;
    end else if (state_next == SPACE && run_next == CNT_W'(WGAP_MIN) && pend) begin
      emit_space = 1'b1;
      pend_next  = 1'b0;
    end

    if (emit_letter) begin
      pattern_next = '0;
      len_next     = '0;
      ovf_next     = 1'b0;
    end else begin
      pattern_next = buf_pattern;
      len_next     = buf_len;
      ovf_next     = buf_ovf;
    end
  end

  assign bus.ascii = ascii_q;
  assign bus.start = start_q;
  assign bus.state = state;

endmodule

// File: tb/tb_top_block.sv
// Bench for the Morse receiver. Each stimulus segment starts from reset; the
// reference model tokenises the segment into mark/space runs, spells symbols
// as dot/dash strings and looks them up in a Morse code table, producing the
// expected (cycle, character) strobes.
module tb_top_block;
  import morse_pkg::*;

  localparam int DASH_MIN = 2;
  localparam int LGAP_MIN = 2;
  localparam int WGAP_MIN = 5;

  logic clk = 1'b0;
  logic reset;

  morse_if mif ();

  top_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_vec;
  int          n_fail;
  logic [31:0] exp_q[$];
  bit          stim_q[$];
  logic [7:0]  last_char;
  logic [7:0]  code_tab[string];

  string codes[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] decode(input string sym);
    if (sym.len() > MAX_ELEM) return 8'h3F;
    if (code_tab.exists(sym)) return code_tab[sym];
    return 8'h3F;
  endfunction

  task automatic model_run();
    int    n;
    int    i;
    int    j;
    int    m;
    int    z;
    string sym;
    bit    pend;
    n    = stim_q.size();
    i    = 0;
    sym  = "";
    pend = 0;
    while (i < n) begin
      if (stim_q[i]) begin
        m = 0;
        while (i < n && stim_q[i]) begin
          m++;
          i++;
        end
        if (i < n) begin
          if (m >= DASH_MIN) sym = {sym, "-"};
          else               sym = {sym, "."};
        end
      end else begin
        j = i;
        z = 0;
        while (i < n && !stim_q[i]) begin
          z++;
          i++;
        end
        if (sym.len() > 0 && z >= LGAP_MIN) begin
          last_char = decode(sym);
          exp_q.push_back({8'h00, 16'(j + LGAP_MIN - 1), last_char});
          sym  = "";
          pend = 1;
        end
        if (pend && z >= WGAP_MIN) begin
          last_char = 8'h20;
          exp_q.push_back({8'h00, 16'(j + WGAP_MIN - 1), last_char});
          pend = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_bits(input string s);
    for (int k = 0; k < s.len(); k++) begin
      if (s[k] == "1") stim_q.push_back(1'b1);
      else if (s[k] == "0") stim_q.push_back(1'b0);
    end
  endtask

  task automatic add_random(input int nruns);
    int m;
    int z;
    int r;
    repeat ($urandom_range(0, 3)) stim_q.push_back(1'b0);
    repeat (nruns) begin
      m = ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(2, 18);
      repeat (m) stim_q.push_back(1'b1);
      r = $urandom_range(0, 99);
      if (r < 55)      z = 1;
      else if (r < 85) z = $urandom_range(2, 4);
      else             z = $urandom_range(5, 20);
      repeat (z) stim_q.push_back(1'b0);
    end
  endtask

  // Asserts reset between clock edges (asynchronously), holds it for the
  // given number of edges with din toggling, releases on a falling edge.
  task automatic do_reset(input int cycles);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_ascii", mif.ascii, 8'h00);
    check("rst_async_start", mif.start, 1'b0);
    check("rst_async_state", 32'(mif.state), 32'(IDLE));
    repeat (cycles) begin
      mif.din = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_ascii", mif.ascii, 8'h00);
      check("rst_start", mif.start, 1'b0);
    end
    mif.din = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_segment(input string tag);
    int          n_obs;
    int          n_exp;
    logic [31:0] e;
    exp_q.delete();
    last_char = 8'h00;
    model_run();
    n_exp = exp_q.size();
    n_obs = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      mif.din = stim_q[i];
      @(posedge clk);
      #1;
      if (mif.start !== 1'b0) begin
        n_obs++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_strobe"}, {8'h00, 16'(i), mif.ascii}, e);
        end
      end
    end
    check({tag, "_count"}, 32'(n_obs), 32'(n_exp));
    check({tag, "_hold"}, mif.ascii, last_char);
    stim_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 36; k++) begin
      code_tab[codes[k]] = (k < 26) ? 8'(8'h41 + k) : 8'(8'h30 + k - 26);
    end
    n_vec   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    mif.din = 1'b0;

    // Reset held with din toggling, then idle zeros produce nothing.
    do_reset(8);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("idle_start", mif.start, 1'b0);
      check("idle_ascii", mif.ascii, 8'h00);
    end

    // SOS TEST MSG
    do_reset(2);
    add_bits("0 10101 000 11101110111 000 10101 0000000 111 000 1 000 10101 000 111 0000000");
    add_bits("1110111 000 10101 000 1110111010000000 1");
    run_segment("sos");

    // Overflow and unmapped patterns
    do_reset(2);
    add_bits("1010101010101 000");
    run_segment("ovf");
    do_reset(2);
    add_bits("1010111 0111 000");
    run_segment("unk");

    // Short vs long mark, then a long zero run giving a single space
    do_reset(2);
    add_bits("1 000 111111 000");
    repeat (16) stim_q.push_back(1'b0);
    run_segment("mark");

    // Reset mid-symbol discards the partial dash
    do_reset(2);
    add_bits("1110");
    run_segment("pre_rst");
    do_reset(3);
    add_bits("1000");
    run_segment("post_rst");

    // Randomised keying
    for (int s = 0; s < 8; s++) begin
      do_reset(1);
      add_random(40);
      run_segment($sformatf("rnd%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
